// File: rtl/instr_fetch_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_reg_pkg
// Description : Shared accumulator-CPU constants: widths, opcodes, instruction
//               field positions and the fetch-state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_fetch_reg_pkg;

  localparam int CPU_ADDR_W  = 10;
  localparam int CPU_INSTR_W = 16;
  localparam int CPU_OPC_W   = 6;
  localparam int CPU_IMM_W   = 10;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 10;
  localparam int IMM_MSB = 9;
  localparam int IMM_LSB = 0;

  typedef enum logic [CPU_OPC_W-1:0] {
    OPC_NOP  = 6'h00,
    OPC_LDA  = 6'h01,
    OPC_LDI  = 6'h02,
    OPC_STA  = 6'h03,
    OPC_ADD  = 6'h04,
    OPC_SUB  = 6'h05,
    OPC_AND  = 6'h06,
    OPC_OR   = 6'h07,
    OPC_JMP  = 6'h10,
    OPC_JZ   = 6'h11,
    OPC_HALT = 6'h3F
  } cpu_opcode_e;

  localparam logic [CPU_OPC_W-1:0] CPU_HALT_OPC = OPC_HALT;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_DECODE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_HALTED = 3'd4
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/instr_fetch_reg_pc_counter.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_reg_pc_counter
// Description : Program counter with priority load over increment; the
//               increment wraps naturally at 2^ADDR_W.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_reg_pc_counter
  import instr_fetch_reg_pkg::*;
#(
  parameter int                ADDR_W   = CPU_ADDR_W,
  parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] target_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = target_i;
    end else if (inc_i) begin
      pc_d = pc_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= PC_RESET;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule
`default_nettype wire

// File: rtl/instr_fetch_reg.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_reg
// Description : Fetch FSM and instruction register; splits IR into opcode and
//               imm10. Define IFR_FETCH_TIMEOUT_EN to add the ack-wait
//               timeout and the fetch_err output.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_reg
  import instr_fetch_reg_pkg::*;
#(
  parameter int                ADDR_W   = CPU_ADDR_W,
  parameter int                INSTR_W  = CPU_INSTR_W,
  parameter int                OPC_W    = CPU_OPC_W,
  parameter logic [ADDR_W-1:0] PC_RESET = '0,
  parameter logic [OPC_W-1:0]  HALT_OPC = CPU_HALT_OPC
`ifdef IFR_FETCH_TIMEOUT_EN
  ,
  parameter int                TIMEOUT  = 16
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               pc_load,
  input  logic [ADDR_W-1:0]  pc_target,
  input  logic               stall,
  output logic               instr_valid,
  output logic [OPC_W-1:0]   opcode,
  output logic [9:0]         imm10,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted
`ifdef IFR_FETCH_TIMEOUT_EN
  ,
  output logic               fetch_err
`endif
);

  fetch_state_e       state_q;
  fetch_state_e       state_d;
  logic [INSTR_W-1:0] ir_q;
  logic               mem_req_q;
  logic               instr_valid_q;
  logic               halted_q;
  logic               ir_load_w;
  logic               pc_load_w;
  logic               pc_inc_w;
  logic [OPC_W-1:0]   ir_opc_w;

  assign ir_opc_w = ir_q[OPC_MSB -: OPC_W];

`ifdef IFR_FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt_q;
  logic             fetch_err_q;
  logic             timeout_w;
`endif

  always_comb begin
    state_d   = state_q;
    ir_load_w = 1'b0;
    pc_inc_w  = 1'b0;
    pc_load_w = pc_load && (state_q != ST_HALTED);
`ifdef IFR_FETCH_TIMEOUT_EN
    timeout_w = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        // A branch load discards any word arriving in the same cycle.
        if (pc_load) begin
          state_d = ST_REQ;
        end else if (mem_ack) begin
          ir_load_w = 1'b1;
          pc_inc_w  = 1'b1;
          state_d   = ST_DECODE;
        end
`ifdef IFR_FETCH_TIMEOUT_EN
        else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
          timeout_w = 1'b1;
          state_d   = ST_HALTED;
        end
`endif
      end
      ST_DECODE: begin
        if (ir_opc_w == HALT_OPC) begin
          state_d = ST_HALTED;
        end else if (stall) begin
          state_d = ST_HOLD;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_HOLD: begin
        if (!stall) begin
          state_d = ST_REQ;
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      ir_q          <= '0;
      mem_req_q     <= 1'b0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      if (ir_load_w) begin
        ir_q <= mem_rdata;
      end
      mem_req_q     <= (state_d == ST_REQ);
      instr_valid_q <= (state_d == ST_DECODE);
      halted_q      <= (state_d == ST_HALTED);
    end
  end

`ifdef IFR_FETCH_TIMEOUT_EN
  // Counter is held at zero outside REQ, so every entry to REQ starts fresh.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q  <= '0;
      fetch_err_q <= 1'b0;
    end else begin
      if ((state_q != ST_REQ) || pc_load || mem_ack) begin
        wait_cnt_q <= '0;
      end else if (!timeout_w) begin
        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
      end
      fetch_err_q <= fetch_err_q | timeout_w;
    end
  end

  assign fetch_err = fetch_err_q;
`endif

  instr_fetch_reg_pc_counter #(
    .ADDR_W   (ADDR_W),
    .PC_RESET (PC_RESET)
  ) u_pc_counter (
    .clk      (clk),
    .rst      (rst),
    .load_i   (pc_load_w),
    .target_i (pc_target),
    .inc_i    (pc_inc_w),
    .pc_o     (pc)
  );

  assign mem_req     = mem_req_q;
  assign mem_addr    = pc;
  assign instr_valid = instr_valid_q;
  assign halted      = halted_q;
  assign opcode      = ir_opc_w;
  assign imm10       = ir_q[IMM_MSB:IMM_LSB];

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_reg
// Description : Directed scoreboard bench for instr_fetch_reg.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        mem_req;
  logic [9:0]  mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic        pc_load = 1'b0;
  logic [9:0]  pc_target = '0;
  logic        stall = 1'b0;
  logic        instr_valid;
  logic [5:0]  opcode;
  logic [9:0]  imm10;
  logic [9:0]  pc;
  logic        halted;
`ifdef IFR_FETCH_TIMEOUT_EN
  logic        fetch_err;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [5:0] opc;
    logic [9:0] imm;
    logic [9:0] pc;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  instr_fetch_reg dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .pc_load     (pc_load),
    .pc_target   (pc_target),
    .stall       (stall),
    .instr_valid (instr_valid),
    .opcode      (opcode),
    .imm10       (imm10),
    .pc          (pc),
    .halted      (halted)
`ifdef IFR_FETCH_TIMEOUT_EN
    ,
    .fetch_err   (fetch_err)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [5:0] o, input logic [9:0] i, input logic [9:0] p);
    exp_t e;
    e.opc = o;
    e.imm = i;
    e.pc  = p;
    sb.push_back(e);
  endtask

  // Monitor: every valid strobe must match the oldest queued expectation.
  always @(posedge clk) begin
    #1;
    if (!rst && instr_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 32'(instr_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_opcode", 32'(opcode), 32'(e.opc));
        chk("sb_imm10", 32'(imm10), 32'(e.imm));
        chk("sb_pc", 32'(pc), 32'(e.pc));
      end
    end
  end

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, "_halted"}, 32'(halted), 32'd0);
    chk({tag, "_opcode"}, 32'(opcode), 32'd0);
    chk({tag, "_imm10"}, 32'(imm10), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_pc"}, 32'(pc), 32'd0);
`ifdef IFR_FETCH_TIMEOUT_EN
    chk({tag, "_fetch_err"}, 32'(fetch_err), 32'd0);
`endif
  endtask

  initial begin
    nxt();
    nxt();
    chk_reset_state("reset");

    // First fetch: ack one cycle after the request appears.
    rst = 1'b0;
    en  = 1'b1;
    nxt();
    chk("req1_mem_req", 32'(mem_req), 32'd1);
    chk("req1_addr", 32'(mem_addr), 32'd0);
    en        = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 16'h0A05;
    push(6'h02, 10'h205, 10'd1);
    nxt();
    mem_ack   = 1'b0;
    pc_load   = 1'b1;
    pc_target = 10'h3FF;
    nxt();

    // Fetch at the last address; pc must wrap to zero.
    pc_load = 1'b0;
    chk("wrap_addr", 32'(mem_addr), 32'h3FF);
    chk("wrap_mem_req", 32'(mem_req), 32'd1);
    mem_ack   = 1'b1;
    mem_rdata = 16'h0FFF;
    push(6'h03, 10'h3FF, 10'd0);
    nxt();
    mem_ack = 1'b0;
    stall   = 1'b1;
    chk("wrap_pc", 32'(pc), 32'd0);

    // Stall through three HOLD cycles; IR fields must hold.
    for (int i = 0; i < 3; i++) begin
      nxt();
      chk("hold_mem_req", 32'(mem_req), 32'd0);
      chk("hold_valid", 32'(instr_valid), 32'd0);
    end
    chk("hold_opcode", 32'(opcode), 32'h03);
    chk("hold_imm10", 32'(imm10), 32'h3FF);
    stall = 1'b0;
    nxt();
    chk("after_stall_req", 32'(mem_req), 32'd1);
    chk("after_stall_addr", 32'(mem_addr), 32'd0);

    // Branch load coincident with ack: word is dropped.
    mem_ack   = 1'b1;
    mem_rdata = 16'h1234;
    pc_load   = 1'b1;
    pc_target = 10'h100;
    nxt();
    mem_ack = 1'b0;
    pc_load = 1'b0;
    chk("branch_valid", 32'(instr_valid), 32'd0);
    chk("branch_req", 32'(mem_req), 32'd1);
    chk("branch_addr", 32'(mem_addr), 32'h100);
    chk("branch_opcode_kept", 32'(opcode), 32'h03);

    // HALT fetch.
    mem_ack   = 1'b1;
    mem_rdata = 16'hFC00;
    push(6'h3F, 10'h000, 10'h101);
    nxt();
    mem_ack = 1'b0;
    nxt();
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_mem_req", 32'(mem_req), 32'd0);
    en        = 1'b1;
    pc_load   = 1'b1;
    pc_target = 10'h055;
    for (int i = 0; i < 2; i++) begin
      nxt();
      chk("halted_mem_req", 32'(mem_req), 32'd0);
      chk("halted_stays", 32'(halted), 32'd1);
      chk("halted_pc", 32'(pc), 32'h101);
    end
    en      = 1'b0;
    pc_load = 1'b0;
    rst     = 1'b1;
    nxt();
    chk_reset_state("rst_after_halt");

    // Back-to-back fetches with immediate acks: one instruction per 2 cycles.
    rst = 1'b0;
    en  = 1'b1;
    nxt();
    en        = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 16'h1C2A;
    push(6'h07, 10'h02A, 10'd1);
    nxt();
    mem_ack = 1'b0;
    chk("b2b_valid1", 32'(instr_valid), 32'd1);
    nxt();
    chk("b2b_req2", 32'(mem_req), 32'd1);
    chk("b2b_addr2", 32'(mem_addr), 32'd1);
    mem_ack   = 1'b1;
    mem_rdata = 16'h8001;
    push(6'h20, 10'h001, 10'd2);
    nxt();
    mem_ack = 1'b0;
    chk("b2b_valid2", 32'(instr_valid), 32'd1);
    nxt();
    mem_ack = 1'b1;
    mem_rdata = 16'hFC00;
    push(6'h3F, 10'h000, 10'd3);
    nxt();
    mem_ack = 1'b0;
    nxt();
    chk("b2b_halted", 32'(halted), 32'd1);

`ifdef IFR_FETCH_TIMEOUT_EN
    // Ack never arrives: error raised on the sixteenth REQ cycle.
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    en  = 1'b1;
    nxt();
    en = 1'b0;
    for (int i = 0; i < 15; i++) nxt();
    chk("to_err_early", 32'(fetch_err), 32'd0);
    chk("to_req_early", 32'(mem_req), 32'd1);
    nxt();
    chk("to_err", 32'(fetch_err), 32'd1);
    chk("to_halted", 32'(halted), 32'd1);
    chk("to_mem_req", 32'(mem_req), 32'd0);
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    en  = 1'b1;
    nxt();
    en  = 1'b0;
    rst = 1'b1;
    nxt();
    chk_reset_state("rst_mid_req");
    rst       = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 16'h0A05;
    nxt();
    mem_ack = 1'b0;
    nxt();
    chk("late_ack_ignored", 32'(opcode), 32'd0);
`endif

    nxt();
    nxt();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
